// File: rtl/health_alarm_escalator.sv
// Multi-channel health alarm: per-channel persistence filters, saturating severity sum,
// and an acknowledge/escalation FSM driving the warning display and nurse call.
module health_alarm_escalator #(
  parameter int NUM_CH     = 5,
  parameter int SEV_W      = 3,
  parameter int PERSIST    = 3,
  parameter int ESC_CYCLES = 8
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic [2*NUM_CH-1:0]   chLevel,
  input  logic                  ack,
  output logic [SEV_W-1:0]      warning,
  output logic [NUM_CH-1:0]     activeMask,
  output logic                  alarm,
  output logic                  escalated
);

  localparam int CNT_W = $clog2(PERSIST + 1);
  localparam int SUM_W = $clog2(3 * NUM_CH + 1);
  localparam int CMP_W = (SUM_W > SEV_W) ? SUM_W : SEV_W;
  localparam int ESC_W = $clog2(ESC_CYCLES) + 1;
  localparam logic [SEV_W-1:0] SEV_MAX = '1;

  typedef enum logic [1:0] {IDLE, ALERT, ACKED, ESCALATED} stateT;

  logic [1:0]            lastRaw [NUM_CH];
  logic [CNT_W-1:0]      cnt     [NUM_CH];
  logic [NUM_CH-1:0][1:0] filt;

  logic [CMP_W-1:0]      sum;
  logic [SEV_W-1:0]      sev;
  logic [NUM_CH-1:0]     mask;

  stateT                 state;
  logic [ESC_W-1:0]      escCnt;
  logic [SEV_W-1:0]      ackLvl;

  // A level reaches filt only on the PERSIST-th consecutive edge sampling it.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_CH; i++) begin
        lastRaw[i] <= '0;
        cnt[i]     <= '0;
      end
      filt <= '0;
    end else begin
      // NOTE: state updates use <= so every channel sees pre-edge values regardless of loop order.
      for (int i = 0; i < NUM_CH; i++) begin
        if (chLevel[2*i +: 2] != lastRaw[i]) begin
          lastRaw[i] <= chLevel[2*i +: 2];
          cnt[i]     <= CNT_W'(1);
          if (PERSIST == 1) filt[i] <= chLevel[2*i +: 2];
        end else if (cnt[i] != CNT_W'(PERSIST)) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
          if (cnt[i] == CNT_W'(PERSIST - 1)) filt[i] <= chLevel[2*i +: 2];
        end
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sum  = '0;
    mask = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sum     = sum + CMP_W'(filt[i]);
      mask[i] = |filt[i];
    end
    sev = (sum > CMP_W'(SEV_MAX)) ? SEV_MAX : sum[SEV_W-1:0];
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      warning    <= '0;
      activeMask <= '0;
    end else begin
      warning    <= sev;
      activeMask <= mask;
    end
  end

  // Moore outputs are registered alongside the state they decode.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      escCnt    <= '0;
      ackLvl    <= '0;
      alarm     <= 1'b0;
      escalated <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sev != '0) begin
            state  <= ALERT;
            escCnt <= '0;
            alarm  <= 1'b1;
          end
        end
        ALERT: begin
          escCnt <= escCnt + ESC_W'(1);
          if (ack) begin
            state  <= ACKED;
            ackLvl <= sev;
            alarm  <= 1'b0;
          end else if (sev == '0) begin
            state <= IDLE;
            alarm <= 1'b0;
          end else if (escCnt == ESC_W'(ESC_CYCLES - 1)) begin
            state     <= ESCALATED;
            escalated <= 1'b1;
          end
        end
        ACKED: begin
          if (sev == '0) begin
            state <= IDLE;
          end else if (sev > ackLvl) begin
            state  <= ALERT;
            escCnt <= '0;
            alarm  <= 1'b1;
          end else begin
            ackLvl <= sev;
          end
        end
        ESCALATED: begin
          if (ack) begin
            state     <= (sev != '0) ? ACKED : IDLE;
            ackLvl    <= sev;
            alarm     <= 1'b0;
            escalated <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          alarm     <= 1'b0;
          escalated <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_health_alarm_escalator.sv
// Randomized and directed bench for health_alarm_escalator against a
// sample-window / alert-age reference model.
module tb_health_alarm_escalator;

  localparam int NUM_CH     = 5;
  localparam int SEV_W      = 3;
  localparam int PERSIST    = 3;
  localparam int ESC_CYCLES = 8;
  localparam int SEV_MAX    = (1 << SEV_W) - 1;

  logic                clock = 1'b0;
  logic                resetN;
  logic [2*NUM_CH-1:0] chLevel;
  logic                ack;
  logic [SEV_W-1:0]    warning;
  logic [NUM_CH-1:0]   activeMask;
  logic                alarm;
  logic                escalated;

  health_alarm_escalator #(
    .NUM_CH(NUM_CH), .SEV_W(SEV_W), .PERSIST(PERSIST), .ESC_CYCLES(ESC_CYCLES)
  ) dut (
    .clock(clock), .resetN(resetN), .chLevel(chLevel), .ack(ack),
    .warning(warning), .activeMask(activeMask), .alarm(alarm), .escalated(escalated)
  );

  always #5 clock = ~clock;

  int testsRun    = 0;
  int testsFailed = 0;

  task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Reference model: filtered level = value of the last PERSIST samples when they all agree.
  typedef enum {M_IDLE, M_ALERT, M_ACKED, M_ESC} mStateT;

  int     win [NUM_CH][PERSIST];
  int     nSamp;
  int     mFilt [NUM_CH];
  mStateT mState;
  int     alertAge;
  int     mAckLvl;
  int     mWarn;
  int     mMask;

  function automatic void modelReset();
    nSamp    = 0;
    mState   = M_IDLE;
    alertAge = 0;
    mAckLvl  = 0;
    mWarn    = 0;
    mMask    = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      mFilt[i] = 0;
      for (int k = 0; k < PERSIST; k++) win[i][k] = 0;
    end
  endfunction

  function automatic void modelEdge(input logic [2*NUM_CH-1:0] lv, input logic a);
    int total;
    int sev;
    bit same;
    total = 0;
    for (int i = 0; i < NUM_CH; i++) total += mFilt[i];
    sev = (total > SEV_MAX) ? SEV_MAX : total;

    case (mState)
      M_IDLE: if (sev > 0) begin mState = M_ALERT; alertAge = 0; end
      M_ALERT: begin
        alertAge++;
        if (a) begin mState = M_ACKED; mAckLvl = sev; end
        else if (sev == 0) mState = M_IDLE;
        else if (alertAge >= ESC_CYCLES) mState = M_ESC;
      end
      M_ACKED: begin
        if (sev == 0) mState = M_IDLE;
        else if (sev > mAckLvl) begin mState = M_ALERT; alertAge = 0; end
        else mAckLvl = sev;
      end
      M_ESC: if (a) begin
        if (sev > 0) begin mState = M_ACKED; mAckLvl = sev; end
        else mState = M_IDLE;
      end
      default: mState = M_IDLE;
    endcase

    mWarn = sev;
    mMask = 0;
    for (int i = 0; i < NUM_CH; i++) if (mFilt[i] != 0) mMask |= (1 << i);

    nSamp++;
    for (int i = 0; i < NUM_CH; i++) begin
      for (int k = PERSIST - 1; k > 0; k--) win[i][k] = win[i][k-1];
      win[i][0] = int'(lv[2*i +: 2]);
      if (nSamp >= PERSIST) begin
        same = 1'b1;
        for (int k = 1; k < PERSIST; k++) if (win[i][k] != win[i][0]) same = 1'b0;
        if (same) mFilt[i] = win[i][0];
      end
    end
  endfunction

  task automatic step(input logic [2*NUM_CH-1:0] lv, input logic a);
    chLevel = lv;
    ack     = a;
    @(posedge clock);
    modelEdge(lv, a);
    #1;
    checkVal("warning",    32'(warning),    32'(mWarn));
    checkVal("activeMask", 32'(activeMask), 32'(mMask));
    checkVal("alarm",      32'(alarm),      32'(mState == M_ALERT || mState == M_ESC));
    checkVal("escalated",  32'(escalated),  32'(mState == M_ESC));
  endtask

  // Called #1 after an edge: reset asserts mid-cycle and releases on the falling edge.
  task automatic midReset();
    resetN = 1'b0;
    #2;
    checkVal("rst_warning",   32'(warning),    32'd0);
    checkVal("rst_mask",      32'(activeMask), 32'd0);
    checkVal("rst_alarm",     32'(alarm),      32'd0);
    checkVal("rst_escalated", 32'(escalated),  32'd0);
    modelReset();
    #2;
    resetN = 1'b1;
  endtask

  localparam logic [2*NUM_CH-1:0] CH0_1   = 10'b00_00_00_00_01;
  localparam logic [2*NUM_CH-1:0] CH1_2   = 10'b00_00_00_10_00;
  localparam logic [2*NUM_CH-1:0] CH02_1  = 10'b00_00_01_00_01;
  localparam logic [2*NUM_CH-1:0] ALL_3   = 10'b11_11_11_11_11;

  initial begin
    logic [2*NUM_CH-1:0] lv;
    int hold;
    modelReset();
    resetN  = 1'b0;
    chLevel = '0;
    ack     = 1'b0;
    #12;
    checkVal("init_warning",   32'(warning),    32'd0);
    checkVal("init_mask",      32'(activeMask), 32'd0);
    checkVal("init_alarm",     32'(alarm),      32'd0);
    checkVal("init_escalated", 32'(escalated),  32'd0);
    resetN = 1'b1;

    // Persistence latency: visible after the 4th edge.
    for (int e = 0; e < 3; e++) step(CH0_1, 1'b0);
    checkVal("t1_early_warning", 32'(warning), 32'd0);
    step(CH0_1, 1'b0);
    checkVal("t1_warning", 32'(warning),    32'd1);
    checkVal("t1_mask",    32'(activeMask), 32'd1);
    checkVal("t1_alarm",   32'(alarm),      32'd1);

    // Escalation on the 8th edge spent in ALERT, then latched.
    for (int e = 0; e < ESC_CYCLES - 1; e++) step(CH0_1, 1'b0);
    checkVal("t4_not_yet", 32'(escalated), 32'd0);
    step(CH0_1, 1'b0);
    checkVal("t4_escalated", 32'(escalated), 32'd1);
    for (int e = 0; e < 5; e++) step('0, 1'b0);
    checkVal("t4_latched", 32'(escalated), 32'd1);
    checkVal("t4_sev0",    32'(warning),   32'd0);
    step('0, 1'b1);
    checkVal("t4_ack_esc",   32'(escalated), 32'd0);
    checkVal("t4_ack_alarm", 32'(alarm),     32'd0);

    // Short glitch is never seen.
    for (int e = 0; e < 2; e++) step(CH1_2, 1'b0);
    for (int e = 0; e < 4; e++) begin
      step('0, 1'b0);
      checkVal("t2_warning", 32'(warning), 32'd0);
      checkVal("t2_alarm",   32'(alarm),   32'd0);
    end

    // Ack then a higher severity re-alerts.
    for (int e = 0; e < 4; e++) step(CH0_1, 1'b0);
    step(CH0_1, 1'b1);
    checkVal("t5_acked", 32'(alarm), 32'd0);
    for (int e = 0; e < 4; e++) step(CH02_1, 1'b0);
    checkVal("t5_warning", 32'(warning), 32'd2);
    checkVal("t5_realert", 32'(alarm),   32'd1);

    // Saturation.
    for (int e = 0; e < 4; e++) step(ALL_3, 1'b0);
    checkVal("t3_warning", 32'(warning),    32'(SEV_MAX));
    checkVal("t3_mask",    32'(activeMask), 32'h1f);

    // Reset mid-escalation, then full latency again.
    for (int e = 0; e < ESC_CYCLES + 2; e++) step(ALL_3, 1'b0);
    checkVal("t6_escalated", 32'(escalated), 32'd1);
    midReset();
    for (int e = 0; e < 3; e++) step(ALL_3, 1'b0);
    checkVal("t6_early", 32'(warning), 32'd0);
    step(ALL_3, 1'b0);
    checkVal("t6_warning", 32'(warning), 32'(SEV_MAX));

    // Randomized sparse traffic with occasional ack and reset.
    for (int seg = 0; seg < 300; seg++) begin
      lv = '0;
      for (int i = 0; i < NUM_CH; i++)
        if ($urandom_range(0, 2) == 0) lv[2*i +: 2] = 2'($urandom_range(1, 3));
      hold = $urandom_range(1, 6);
      for (int e = 0; e < hold; e++) step(lv, ($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 99) == 0) midReset();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
